task_ctrl_param: RTL and testbench

Parametrised task control block for the hardware scheduler; one instance per task.
- Decodes the shared operation bus and holds task state, priority and remaining execution hits.
- Ages priority while the task waits, tracks dispatch/finish.
- Presents a registered {id, priority} request to the priority sorter.
- Successor to the fixed-width task blocks; adds broadcast ops, saturating aging, running tracking and a request-valid flag.

---
 rtl/task_pkg.sv | 30 +++
 rtl/task_age_timer.sv | 28 ++
 rtl/task_ctrl_param.sv | 171 +++++++++++++++++
 tb/tb_task_ctrl_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_pkg.sv
// Shared definitions for the per-task scheduler control blocks.
package task_pkg;

    // Opcode field values on the operation bus
    localparam logic [3:0] OP_READY    = 4'b0001;
    localparam logic [3:0] OP_SUSPEND  = 4'b0010;
    localparam logic [3:0] OP_WAIT     = 4'b0011;
    localparam logic [3:0] OP_KILL     = 4'b0100;
    localparam logic [3:0] OP_KILL_ALT = 4'b1100;
    localparam logic [3:0] OP_SETPRIO  = 4'b0101;
    localparam logic [3:0] OP_SETHIT   = 4'b0110;
    localparam logic [3:0] OP_DISPATCH = 4'b0111;
    localparam logic [3:0] OP_FINISH   = 4'b1111;

    // Task lifecycle states
    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_SUSP  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_TERM  = 2'b11
    } task_state_e;

    // Broadcast target id is all ones of the id width
    function automatic logic [31:0] bcast_id(input int unsigned w);
        if (w >= 32)
            return '1;
        return (32'(1) << w) - 32'd1;
    endfunction

endpackage

// File: rtl/task_age_timer.sv
// Aging prescaler: counts enabled cycles and emits a tick on each period wrap.
module task_age_timer #(
    parameter int unsigned AGE_W      = 32,
    parameter int unsigned AGE_PERIOD = 10000
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    logic [AGE_W-1:0] cnt_q;

    // A clear in the same cycle suppresses the tick so the clearing op wins
    assign tick_c = en && !clr && (cnt_q == AGE_W'(AGE_PERIOD - 1));

    // Counter: clear has priority, then wrap or increment while enabled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (en)
            cnt_q <= tick_c ? '0 : cnt_q + AGE_W'(1);
    end

endmodule

// File: rtl/task_ctrl_param.sv
// Per-task control block: decodes the op bus, tracks state/priority/hits,
// ages priority while waiting and presents a registered sorter request.
module task_ctrl_param
    import task_pkg::*;
#(
    parameter int unsigned TASK_ID    = 6,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned PRIO_W     = 4,
    parameter int unsigned HIT_W      = 8,
    parameter int unsigned HIT_INIT   = 128,
    parameter int unsigned AGE_PERIOD = 10000,
    parameter int unsigned AGE_W      = 32,
    parameter int unsigned OP_W       = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [OP_W-1:0]          in_op,
    output logic [ID_W+PRIO_W-1:0]   out_sorter,
    output logic                     out_valid,
    output logic [1:0]               out_state,
    output logic                     out_running,
    output logic [HIT_W-1:0]         out_hit
);

    localparam logic [ID_W-1:0]  MY_ID    = ID_W'(TASK_ID);
    localparam logic [ID_W-1:0]  BCAST_ID = ID_W'(bcast_id(ID_W));
    localparam int unsigned      PA_W     = (PRIO_W < 4) ? PRIO_W : 4;
    localparam int unsigned      HA_W     = (HIT_W < 4) ? HIT_W : 4;

    task_state_e         state_q, state_d;
    logic [PRIO_W-1:0]   base_q, base_d;
    logic [PRIO_W-1:0]   eff_q, eff_d;
    logic [HIT_W-1:0]    hit_q, hit_d;
    logic                running_q, running_d;

    logic [3:0]          op_arg;
    logic [3:0]          opcode;
    logic [ID_W-1:0]     op_tgt;
    logic [PRIO_W-1:0]   arg_prio;
    logic [HIT_W-1:0]    arg_hit;
    logic                accept_c;
    logic                req_c;
    logic                age_clr_c;
    logic                age_tick_c;
    logic                unused_hi;

    assign op_arg   = in_op[3:0];
    assign opcode   = in_op[7:4];
    assign op_tgt   = in_op[ID_W+7:8];
    assign arg_prio = PRIO_W'(op_arg[PA_W-1:0]);
    assign arg_hit  = HIT_W'(op_arg[HA_W-1:0]);

    // Bits above the target id carry nothing for this block
    generate
        if (OP_W > ID_W + 8) begin : g_hi
            assign unused_hi = ^in_op[OP_W-1:ID_W+8];
        end else begin : g_no_hi
            assign unused_hi = 1'b0;
        end
    endgenerate

    // Terminated tasks ignore every op until reset
    assign accept_c = ((op_tgt == MY_ID) || (op_tgt == BCAST_ID)) && (state_q != ST_TERM);

    // Dispatch request and aging enable share the same condition
    assign req_c = (state_q == ST_READY) && !running_q && (hit_q != '0);

    task_age_timer #(
        .AGE_W      (AGE_W),
        .AGE_PERIOD (AGE_PERIOD)
    ) u_age (
        .CLK    (CLK),
        .RST    (RST),
        .en     (req_c),
        .clr    (age_clr_c),
        .tick_c (age_tick_c)
    );

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_READY;
            base_q    <= '0;
            eff_q     <= '0;
            hit_q     <= HIT_W'(HIT_INIT);
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            eff_q     <= eff_d;
            hit_q     <= hit_d;
            running_q <= running_d;
        end
    end

    // Op decode, next-state and aging boost
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        eff_d     = eff_q;
        hit_d     = hit_q;
        running_d = running_q;
        age_clr_c = 1'b0;

        if (accept_c) begin
            case (opcode)
                OP_READY: begin
                    state_d = ST_READY;
                end
                OP_SUSPEND: begin
                    state_d   = ST_SUSP;
                    running_d = 1'b0;
                end
                OP_WAIT: begin
                    state_d   = ST_WAIT;
                    running_d = 1'b0;
                end
                OP_KILL, OP_KILL_ALT: begin
                    state_d   = ST_TERM;
                    running_d = 1'b0;
                end
                OP_SETPRIO: begin
                    base_d    = arg_prio;
                    eff_d     = arg_prio;
                    age_clr_c = 1'b1;
                end
                OP_SETHIT: begin
                    hit_d = arg_hit;
                end
                OP_DISPATCH: begin
                    if ((state_q == ST_READY) && (hit_q != '0) && !running_q) begin
                        hit_d     = hit_q - HIT_W'(1);
                        running_d = 1'b1;
                        eff_d     = base_q;
                        age_clr_c = 1'b1;
                    end
                end
                OP_FINISH: begin
                    if (running_q) begin
                        running_d = 1'b0;
                        age_clr_c = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // Tick is already masked by any clearing op, so the op wins
        if (age_tick_c && (eff_q != '1))
            eff_d = eff_q + PRIO_W'(1);
    end

    // Output stage: registered view of the post-update task state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_state   <= ST_READY;
            out_running <= 1'b0;
            out_hit     <= HIT_W'(HIT_INIT);
            out_valid   <= 1'b0;
            out_sorter  <= '0;
        end else begin
            out_state   <= state_q;
            out_running <= running_q;
            out_hit     <= hit_q;
            out_valid   <= req_c;
            out_sorter  <= req_c ? {MY_ID, eff_q} : '0;
        end
    end

endmodule

// File: tb/tb_task_ctrl_param.sv
// Scoreboard bench for task_ctrl_param (AGE_PERIOD=8).
module tb_task_ctrl_param;

    localparam int AGE_P = 8;

    logic        CLK;
    logic        RST;
    logic [15:0] in_op;
    logic [7:0]  out_sorter;
    logic        out_valid;
    logic [1:0]  out_state;
    logic        out_running;
    logic [7:0]  out_hit;

    task_ctrl_param #(.AGE_PERIOD(AGE_P)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_op       (in_op),
        .out_sorter  (out_sorter),
        .out_valid   (out_valid),
        .out_state   (out_state),
        .out_running (out_running),
        .out_hit     (out_hit)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int edge_n = 0;
    always @(posedge CLK) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         due;
        logic [1:0] st;
        logic       run;
        logic [7:0] hit;
        logic       vld;
        logic [7:0] srt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference model of the task, in plain integers
    int m_st, m_base, m_eff, m_hit, m_age;
    bit m_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_base = 0; m_eff = 0; m_hit = 128; m_age = 0; m_run = 0;
    endtask

    function automatic bit m_req();
        return (m_st == 0) && !m_run && (m_hit > 0);
    endfunction

    task automatic model_step(input logic [15:0] op);
        int tgt, opc, arg;
        bit acc, req, clr;
        tgt = int'(op[11:8]);
        opc = int'(op[7:4]);
        arg = int'(op[3:0]);
        req = m_req();
        clr = 0;
        acc = ((tgt == 6) || (tgt == 15)) && (m_st != 3);
        if (acc) begin
            case (opc)
                1: m_st = 0;
                2: begin m_st = 1; m_run = 0; end
                3: begin m_st = 2; m_run = 0; end
                4, 12: begin m_st = 3; m_run = 0; end
                5: begin m_base = arg; m_eff = arg; clr = 1; end
                6: m_hit = arg;
                7: if (m_st == 0 && m_hit > 0 && !m_run) begin
                       m_hit--; m_run = 1; m_eff = m_base; clr = 1;
                   end
                15: if (m_run) begin m_run = 0; clr = 1; end
                default: ;
            endcase
        end
        if (clr)
            m_age = 0;
        else if (req) begin
            if (m_age == AGE_P - 1) begin
                m_age = 0;
                if (m_eff < 15) m_eff++;
            end else
                m_age++;
        end
    endtask

    // Expected outputs after the coming edge are the model state now
    task automatic push_exp();
        exp_t e;
        e.due = edge_n + 1;
        e.st  = 2'(m_st);
        e.run = m_run;
        e.hit = 8'(m_hit);
        e.vld = m_req();
        e.srt = m_req() ? 8'((6 << 4) | m_eff) : 8'h00;
        q.push_back(e);
    endtask

    // Entered and left at a falling edge
    task automatic cycle(input logic [15:0] op);
        in_op = op;
        push_exp();
        @(posedge CLK);
        model_step(op);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(16'h0000);
    endtask

    // Reset with an arbitrary op on the bus; checks the held reset values
    task automatic do_reset(input logic [15:0] op_hold);
        in_op = op_hold;
        #2 RST = 1'b1;
        q.delete();
        model_reset();
        @(posedge CLK);
        #1;
        chk("rst_state",   32'(out_state),   32'h0);
        chk("rst_hit",     32'(out_hit),     32'h80);
        chk("rst_valid",   32'(out_valid),   32'h0);
        chk("rst_sorter",  32'(out_sorter),  32'h0);
        chk("rst_running", 32'(out_running), 32'h0);
        @(negedge CLK);
        RST   = 1'b0;
        in_op = 16'h0000;
    endtask

    // Monitor: compares DUT outputs with queued expectations each cycle
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].due <= edge_n) begin
            mon_e = q.pop_front();
            if (mon_e.due == edge_n) begin
                chk("out_state",   32'(out_state),   32'(mon_e.st));
                chk("out_running", 32'(out_running), 32'(mon_e.run));
                chk("out_hit",     32'(out_hit),     32'(mon_e.hit));
                chk("out_valid",   32'(out_valid),   32'(mon_e.vld));
                chk("out_sorter",  32'(out_sorter),  32'(mon_e.srt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [15:0] rop;
    int r;

    initial begin
        RST   = 1'b1;
        in_op = 16'h0000;
        model_reset();
        @(negedge CLK);

        do_reset(16'h0000);
        idle(2);

        // Set priority, dispatch, finish
        cycle(16'h0653);
        idle(2);
        cycle(16'h0670);
        idle(2);
        cycle(16'h06F0);
        idle(2);

        // Reset while a dispatch is on the bus
        cycle(16'h0670);
        do_reset(16'h0670);
        idle(1);

        // Aging up to saturation, then a setprio landing on the tick cycle
        cycle(16'h065E);
        idle(20);
        cycle(16'h0655);
        idle(AGE_P - 1);
        cycle(16'h0652);
        idle(AGE_P + 2);

        // Addressing and broadcast
        cycle(16'h0720);
        idle(1);
        cycle(16'h0F20);
        idle(2);
        cycle(16'h0F10);
        idle(2);

        // Hit exhaustion and no underflow
        cycle(16'h0661);
        cycle(16'h0670);
        cycle(16'h06F0);
        idle(1);
        cycle(16'h0670);
        idle(AGE_P + 2);

        // Termination while running is sticky
        do_reset(16'h0000);
        cycle(16'h0670);
        cycle(16'h06C0);
        cycle(16'h0610);
        cycle(16'h0655);
        idle(AGE_P + 2);
        do_reset(16'h0000);
        idle(2);

        // Randomized ops
        for (int i = 0; i < 700; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                rop = 16'h0000;
                rop[11:8] = 4'($urandom_range(0, 5));
                rop[7:0]  = 8'($urandom);
            end else begin
                rop[15:12] = 4'($urandom);
                rop[11:8]  = (r < 80) ? 4'h6 : 4'hF;
                r = int'($urandom_range(0, 99));
                if      (r < 20) rop[7:4] = 4'h7;
                else if (r < 38) rop[7:4] = 4'hF;
                else if (r < 50) rop[7:4] = 4'h5;
                else if (r < 62) rop[7:4] = 4'h6;
                else if (r < 74) rop[7:4] = 4'h1;
                else if (r < 82) rop[7:4] = 4'h2;
                else if (r < 90) rop[7:4] = 4'h3;
                else if (r < 92) rop[7:4] = ($urandom_range(0, 1) != 0) ? 4'h4 : 4'hC;
                else             rop[7:4] = 4'($urandom_range(8, 14));
                rop[3:0] = 4'($urandom);
            end
            if ((m_st == 3 && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0)
                do_reset(rop);
            else
                cycle(rop);
        end

        // Let the last expectation be compared, then confirm the queue drained
        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("scoreboard_drain", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
